// File: rtl/dbus_uncached_axi_if.sv
// cpu_dbus_if: CPU data-bus port for single-word uncached accesses.
interface cpu_dbus_if;
   logic        read;
   logic        write;
   logic        invalidate;
   logic        stall;
   logic [31:0] address;
   logic [31:0] wrdata;
   logic [31:0] rddata;
   logic [3:0]  byteenable;
   modport master (output read, write, invalidate, address, wrdata, byteenable, input stall, rddata);
   modport slave  (input read, write, invalidate, address, wrdata, byteenable, output stall, rddata);
endinterface

// File: rtl/dbus_uncached_axi.sv
// dbus_uncached_axi: turns uncached CPU word accesses into single-beat AXI transactions.
// Define UNCACHED_WRITE_POSTED_EN to release stall before the write response returns.
package dbus_uncached_axi_pkg;
   typedef struct packed {
      logic [31:0] awaddr;
      logic [7:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        awlock;
      logic [3:0]  awcache;
      logic [2:0]  awprot;
      logic        awvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        wvalid;
      logic        bready;
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        arlock;
      logic [3:0]  arcache;
      logic [2:0]  arprot;
      logic        arvalid;
      logic        rready;
   } axi_req_t;
   typedef struct packed {
      logic        awready;
      logic        wready;
      logic        bvalid;
      logic [1:0]  bresp;
      logic        arready;
      logic        rvalid;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
   } axi_resp_t;
endpackage

module dbus_uncached_axi
   import dbus_uncached_axi_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   cpu_dbus_if.slave dbus,
   output axi_req_t  axi_req,
   input  axi_resp_t axi_resp
);
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rddata_q, rddata_d;
   logic [3:0]  be_q, be_d;
   logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic        arvalid_q, arvalid_d, rready_q, rready_d;
   logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic        idle_ok;
   logic        unused_in;
`ifdef UNCACHED_WRITE_POSTED_EN
   logic        pending_b_q, pending_b_d;
`endif
   assign unused_in = ^{dbus.invalidate, axi_resp.bresp, axi_resp.rresp, axi_resp.rlast};
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rddata_d  = rddata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
`ifdef UNCACHED_WRITE_POSTED_EN
      pending_b_d = pending_b_q & ~(bready_q & axi_resp.bvalid);
      idle_ok     = ~pending_b_q;
`else
      idle_ok     = 1'b1;
`endif
      case (state_q)
         IDLE: if ((dbus.read | dbus.write) && idle_ok) begin
            addr_d    = dbus.address;
            wdata_d   = dbus.wrdata;
            be_d      = dbus.byteenable;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = dbus.write ? WR_REQ : RD_ADDR;
         end
         RD_ADDR: state_d = axi_resp.arready ? RD_DATA : RD_ADDR;
         RD_DATA: if (axi_resp.rvalid) begin
            rddata_d = axi_resp.rdata;
            state_d  = DONE;
         end
         WR_REQ: begin
            aw_done_d = aw_done_q | (awvalid_q & axi_resp.awready);
            w_done_d  = w_done_q | (wvalid_q & axi_resp.wready);
`ifdef UNCACHED_WRITE_POSTED_EN
            if (aw_done_d && w_done_d) begin
               state_d     = DONE;
               pending_b_d = 1'b1;
            end
`else
            state_d = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
`endif
         end
         WR_RESP: state_d = axi_resp.bvalid ? DONE : WR_RESP;
         default: state_d = IDLE;
      endcase
      // handshake outputs are registered from the next state so nothing reaches back from axi_resp
      arvalid_d = state_d == RD_ADDR;
      rready_d  = state_d == RD_DATA;
      awvalid_d = state_d == WR_REQ && !aw_done_d;
      wvalid_d  = state_d == WR_REQ && !w_done_d;
`ifdef UNCACHED_WRITE_POSTED_EN
      bready_d  = pending_b_d;
`else
      bready_d  = state_d == WR_RESP;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rddata_q    <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
`ifdef UNCACHED_WRITE_POSTED_EN
         pending_b_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rddata_q    <= rddata_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
`ifdef UNCACHED_WRITE_POSTED_EN
         pending_b_q <= pending_b_d;
`endif
      end
   end
   always_comb begin
      axi_req         = '0;
      axi_req.awaddr  = addr_q;
      axi_req.awsize  = 3'b010;
      axi_req.awburst = 2'b01;
      axi_req.awvalid = awvalid_q;
      axi_req.wdata   = wdata_q;
      axi_req.wstrb   = be_q;
      axi_req.wlast   = 1'b1;
      axi_req.wvalid  = wvalid_q;
      axi_req.bready  = bready_q;
      axi_req.araddr  = addr_q;
      axi_req.arsize  = 3'b010;
      axi_req.arburst = 2'b01;
      axi_req.arvalid = arvalid_q;
      axi_req.rready  = rready_q;
   end
   assign dbus.stall  = (dbus.read | dbus.write) && state_q != DONE;
   assign dbus.rddata = rddata_q;
endmodule

// File: doc/dbus_uncached_axi.md
# dbus_uncached_axi

Bridges the CPU's uncached data-bus accesses onto the system AXI port. It is a `cpu_dbus_if` slave that converts each single-word read or write into one single-beat AXI transaction, carried as `axi_req_t`/`axi_resp_t`. It holds `stall` until that transaction completes. It sits between the memory stage's uncached path and the AXI crossbar, beside the D$.

## Interface

Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `dbus`  `cpu_dbus_if.slave`  —  uncached CPU requests: `read`, `write`, `invalidate`, `address`, `wrdata`, `byteenable`, `stall`, `rddata`.
- `axi_req`  out  `axi_req_t`  AXI master request channels.
- `axi_resp`  in  `axi_resp_t`  AXI slave responses.

## Operation

- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- **Request capture.** In IDLE with `read|write` set (and no pending B, see Configuration):
  - Latch `address`, `wrdata` and `byteenable` into registers.
  - Go to RD_ADDR for a read, or WR_REQ for a write.
  - If both `read` and `write` are set, the write is served.
  - `invalidate` is ignored; it never raises `stall`.
- **Read path.**
  - RD_ADDR: drive `arvalid=1`. On `arready`, go to RD_DATA.
  - RD_DATA: drive `rready=1`. On `rvalid`, capture `rdata` into the `rddata` register and go to DONE.
- **Write path.**
  - WR_REQ: drive `awvalid` and `wvalid` together, each gated by its own done flag. An accepted channel deasserts independently.
  - When both channels are accepted (possibly in the same cycle), go to WR_RESP.
  - WR_RESP: drive `bready=1`. On `bvalid`, go to DONE.
- DONE: `stall=0` for exactly one cycle, then go to IDLE.
- **Fixed AXI fields.**
  - `arlen=awlen=0`, `arsize=awsize=3'b010`, `arburst=awburst=2'b01`.
  - `arlock=awlock=0`, `arcache=awcache=0`, `arprot=awprot=0`.
  - `wlast=1` whenever `wvalid=1`.
  - `wstrb` = latched `byteenable`; `araddr`/`awaddr`/`wdata` = latched values.
- **Stall.** `stall = (read|write) && state!=DONE`, combinational.
- **Response codes.** Nonzero `rresp`/`bresp` is ignored. Read data is still returned.
- **Reset** (at any time, including mid-transaction):
  - State returns to IDLE; done flags and pending B clear; `rddata` = 0.
  - All AXI valid/ready outputs are 0 and all address/data fields are 0.
  - The in-flight AXI transaction is abandoned; the interconnect resets with the same reset.

## Timing

- All AXI outputs are decoded from registered state or latched registers; none depends combinationally on `axi_resp`.
- Minimum read, with `arready=1` at first assertion and `rvalid` in the next cycle:
  - Request seen in cycle 0; `arvalid` in cycle 1; `rvalid` in cycle 2.
  - `stall` low in cycle 3.
  - Total: 3 stall cycles.
- Minimum write (non-posted): AW/W in cycle 1, B in cycle 2, `stall` low in cycle 3.
- `rddata` is stable from DONE until the next read's capture.
- Back-to-back: the next request is accepted in IDLE, one cycle after DONE.
- Valid signals never drop before their handshake.

## Configuration

- Macro: `UNCACHED_WRITE_POSTED_EN`.
- **Defined:**
  - A write leaves WR_REQ directly to DONE once AW and W are both accepted, and sets `pending_b`.
  - `bready=pending_b`; `pending_b` clears on `bvalid`.
  - While `pending_b=1`, IDLE does not accept a new read or write; `stall` stays high.
  - Minimum write: `stall` low in cycle 2.
- **Undefined:**
  - WR_RESP is used as described; no `pending_b` register exists.
  - Write latency is as in Timing.

## Test plan

- **Single read:** read `0x1FD0_F000`, `arready=1`, `rdata=0xDEADBEEF` one cycle later.
  - Expect `araddr=0x1FD0_F000`, `arsize=2`, `arlen=0`.
  - Expect `stall` high 3 cycles, then `rddata=0xDEADBEEF`.
- **Write, independent handshakes:** write `0x1FD0_F004`, `wrdata=0x12345678`, `be=4'b0011`. `awready` arrives 3 cycles before `wready`.
  - Expect `awvalid` to drop after its handshake while `wvalid` holds.
  - Expect `wstrb=0011` and `wlast=1`.
  - Expect `stall` to release only after `bvalid` (unless posted).
- **Back-to-back:** write then read.
  - Expect the second `arvalid` no earlier than 2 cycles after write DONE.
  - Expect no overlap of AW and AR.
- **Reset mid-transaction:** pull `rst_n` low during RD_DATA.
  - Expect all valids 0 and `rddata=0` immediately (asynchronously).
  - Expect an idle FSM after release.
- **Invalidate and error response:**
  - `invalidate=1` alone: expect `stall=0` and no AXI activity.
  - Read with `rresp=2'b10`, `rdata=0x0000_00AA`: expect `rddata=0xAA`.
- **Posted mode** (macro defined): write followed by read while `bvalid` is delayed 5 cycles.
  - Expect the write's `stall` low at cycle 2.
  - Expect the read's `arvalid` held until after `bvalid`.
